// File: rtl/bram_seq_ctrl.sv
// Sequencer for a single-port BRAM: writes seed+k patterns, reads them back, drains the read pipe.
// Optional read-back compare is enabled by defining BRAM_SEQ_CTRL_COMPARE_EN.
module bram_seq_ctrl #(
  parameter int unsigned DWIDTH     = 16,
  parameter int unsigned AWIDTH     = 12,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_run,
  input  logic [1:0]        i_mode,
  input  logic [AWIDTH-1:0] i_base_addr,
  input  logic [AWIDTH-1:0] i_num_cnt,
  input  logic [DWIDTH-1:0] i_seed,
  output logic              o_idle,
  output logic              o_write,
  output logic              o_read,
  output logic              o_drain,
  output logic              o_done,
  output logic [AWIDTH-1:0] addr0,
  output logic              ce0,
  output logic              we0,
  output logic [DWIDTH-1:0] d0,
  input  logic [DWIDTH-1:0] q0,
  output logic              o_valid,
  output logic [DWIDTH-1:0] o_mem_data,
  output logic [AWIDTH-1:0] o_err_cnt,
  output logic              o_err
);

  localparam int unsigned DCW        = 3;
  localparam logic [1:0]  MODE_RD    = 2'b01;
  localparam logic [1:0]  MODE_WR_RD = 2'b10;
  localparam logic [1:0]  MODE_RSVD  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [AWIDTH-1:0]     r_k, w_k_nxt;
  logic [DCW-1:0]        r_dcnt, w_dcnt_nxt;
  logic [1:0]            r_mode, w_mode_nxt;
  logic [AWIDTH-1:0]     r_base, w_base_nxt;
  logic [AWIDTH-1:0]     r_cnt, w_cnt_nxt;
  logic [DWIDTH-1:0]     r_seed, w_seed_nxt;
  logic                  w_last;

  logic                  r_idle, r_write, r_read, r_drain, r_done;
  logic                  r_ce0, r_we0;
  logic [AWIDTH-1:0]     r_addr0;
  logic [DWIDTH-1:0]     r_d0;
  logic                  w_ce0_nxt, w_we0_nxt;
  logic [AWIDTH-1:0]     w_addr0_nxt;
  logic [DWIDTH-1:0]     w_d0_nxt;
  logic [RD_LATENCY-1:0] r_vpipe;
  logic                  w_rd_issue;

  // Next-state, counters and the BRAM port values for the coming cycle
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_dcnt_nxt  = r_dcnt;
    w_mode_nxt  = r_mode;
    w_base_nxt  = r_base;
    w_cnt_nxt   = r_cnt;
    w_seed_nxt  = r_seed;
    w_last      = (r_k == r_cnt - AWIDTH'(1));

    case (r_state)
      S_IDLE: begin
        if (i_run && (i_mode != MODE_RSVD)) begin
          w_mode_nxt = i_mode;
          w_base_nxt = i_base_addr;
          w_cnt_nxt  = i_num_cnt;
          w_seed_nxt = i_seed;
          w_k_nxt    = '0;
          if (i_num_cnt == '0)
            w_state_nxt = S_DONE;
          else if (i_mode == MODE_RD)
            w_state_nxt = S_READ;
          else
            w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (w_last) begin
          w_k_nxt     = '0;
          w_state_nxt = (r_mode == MODE_WR_RD) ? S_READ : S_DONE;
        end else begin
          w_k_nxt = r_k + AWIDTH'(1);
        end
      end
      S_READ: begin
        if (w_last) begin
          w_k_nxt     = '0;
          w_dcnt_nxt  = '0;
          w_state_nxt = S_DRAIN;
        end else begin
          w_k_nxt = r_k + AWIDTH'(1);
        end
      end
      S_DRAIN: begin
        // The last issued read surfaces on o_valid in the final drain cycle
        if (r_dcnt == DCW'(RD_LATENCY - 1))
          w_state_nxt = S_DONE;
        else
          w_dcnt_nxt = r_dcnt + DCW'(1);
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    w_ce0_nxt   = (w_state_nxt == S_WRITE) || (w_state_nxt == S_READ);
    w_we0_nxt   = (w_state_nxt == S_WRITE);
    w_addr0_nxt = w_ce0_nxt ? (w_base_nxt + w_k_nxt) : '0;
    w_d0_nxt    = w_we0_nxt ? (w_seed_nxt + DWIDTH'(w_k_nxt)) : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_dcnt  <= '0;
      r_mode  <= '0;
      r_base  <= '0;
      r_cnt   <= '0;
      r_seed  <= '0;
      r_idle  <= 1'b1;
      r_write <= 1'b0;
      r_read  <= 1'b0;
      r_drain <= 1'b0;
      r_done  <= 1'b0;
      r_ce0   <= 1'b0;
      r_we0   <= 1'b0;
      r_addr0 <= '0;
      r_d0    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_dcnt  <= w_dcnt_nxt;
      r_mode  <= w_mode_nxt;
      r_base  <= w_base_nxt;
      r_cnt   <= w_cnt_nxt;
      r_seed  <= w_seed_nxt;
      r_idle  <= (w_state_nxt == S_IDLE);
      r_write <= (w_state_nxt == S_WRITE);
      r_read  <= (w_state_nxt == S_READ);
      r_drain <= (w_state_nxt == S_DRAIN);
      r_done  <= (w_state_nxt == S_DONE);
      r_ce0   <= w_ce0_nxt;
      r_we0   <= w_we0_nxt;
      r_addr0 <= w_addr0_nxt;
      r_d0    <= w_d0_nxt;
    end
  end

  // Read-valid pipeline matched to the BRAM read latency
  assign w_rd_issue = r_ce0 && !r_we0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_vpipe <= '0;
    else
      r_vpipe <= RD_LATENCY'({r_vpipe, w_rd_issue});
  end

  assign o_idle     = r_idle;
  assign o_write    = r_write;
  assign o_read     = r_read;
  assign o_drain    = r_drain;
  assign o_done     = r_done;
  assign addr0      = r_addr0;
  assign ce0        = r_ce0;
  assign we0        = r_we0;
  assign d0         = r_d0;
  assign o_valid    = r_vpipe[RD_LATENCY-1];
  assign o_mem_data = q0;

`ifdef BRAM_SEQ_CTRL_COMPARE_EN
  logic [AWIDTH-1:0] r_j, w_j_nxt;
  logic [AWIDTH-1:0] r_err_cnt, w_err_cnt_nxt;
  logic              r_err;
  logic              w_accept;
  logic [DWIDTH-1:0] w_exp;

  assign w_accept = (r_state == S_IDLE) && i_run && (i_mode != MODE_RSVD);
  assign w_exp    = r_seed + DWIDTH'(r_j);

  // Returned word j is checked against seed+j; the error count saturates
  always_comb begin
    w_j_nxt       = r_j;
    w_err_cnt_nxt = r_err_cnt;
    if (w_accept) begin
      w_j_nxt       = '0;
      w_err_cnt_nxt = '0;
    end else if (o_valid) begin
      w_j_nxt = r_j + AWIDTH'(1);
      if ((q0 != w_exp) && (r_err_cnt != '1))
        w_err_cnt_nxt = r_err_cnt + AWIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_j       <= '0;
      r_err_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_j       <= w_j_nxt;
      r_err_cnt <= w_err_cnt_nxt;
      r_err     <= (w_err_cnt_nxt != '0);
    end
  end

  assign o_err_cnt = r_err_cnt;
  assign o_err     = r_err;
`else
  assign o_err_cnt = '0;
  assign o_err     = 1'b0;
`endif

endmodule

// File: tb/tb_bram_seq_ctrl.sv
// Directed bench for bram_seq_ctrl: one instance at read latency 1, one at read latency 3.
module tb_bram_seq_ctrl;

`ifdef BRAM_SEQ_CTRL_COMPARE_EN
  localparam bit CMP = 1'b1;
`else
  localparam bit CMP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        run, sel;
  logic [1:0]  mode;
  logic [11:0] base, cnt;
  logic [15:0] seed;
  logic        run_a, run_b;

  logic        idle_a, write_a, read_a, drain_a, done_a, ce0_a, we0_a, valid_a, err_a;
  logic [11:0] addr0_a, errc_a;
  logic [15:0] d0_a, q0_a, mdata_a;
  logic        idle_b, write_b, read_b, drain_b, done_b, ce0_b, we0_b, valid_b, err_b;
  logic [11:0] addr0_b, errc_b;
  logic [15:0] d0_b, q0_b, mdata_b;

  logic [4:0]  s_flags;
  logic        s_ce0, s_we0, s_valid, s_err;
  logic [11:0] s_addr0, s_errc;
  logic [15:0] s_d0, s_mdata;

  logic [15:0] mem_a [4096];
  logic [15:0] mem_b [4096];
  logic [15:0] qb_p [3];
  logic        pl_we;
  logic [11:0] pl_addr;
  logic [15:0] pl_data;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign run_a = run & ~sel;
  assign run_b = run & sel;

  bram_seq_ctrl #(.DWIDTH(16), .AWIDTH(12), .RD_LATENCY(1)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .i_run(run_a), .i_mode(mode), .i_base_addr(base),
    .i_num_cnt(cnt), .i_seed(seed), .o_idle(idle_a), .o_write(write_a), .o_read(read_a),
    .o_drain(drain_a), .o_done(done_a), .addr0(addr0_a), .ce0(ce0_a), .we0(we0_a),
    .d0(d0_a), .q0(q0_a), .o_valid(valid_a), .o_mem_data(mdata_a),
    .o_err_cnt(errc_a), .o_err(err_a)
  );

  bram_seq_ctrl #(.DWIDTH(16), .AWIDTH(12), .RD_LATENCY(3)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .i_run(run_b), .i_mode(mode), .i_base_addr(base),
    .i_num_cnt(cnt), .i_seed(seed), .o_idle(idle_b), .o_write(write_b), .o_read(read_b),
    .o_drain(drain_b), .o_done(done_b), .addr0(addr0_b), .ce0(ce0_b), .we0(we0_b),
    .d0(d0_b), .q0(q0_b), .o_valid(valid_b), .o_mem_data(mdata_b),
    .o_err_cnt(errc_b), .o_err(err_b)
  );

  // BRAM models: latency 1 for instance a, latency 3 (with preload port) for instance b
  always @(posedge clk) begin
    if (ce0_a && we0_a) mem_a[addr0_a] <= d0_a;
    if (ce0_a) q0_a <= mem_a[addr0_a];
  end

  always @(posedge clk) begin
    if (pl_we) mem_b[pl_addr] <= pl_data;
    else if (ce0_b && we0_b) mem_b[addr0_b] <= d0_b;
    if (ce0_b) qb_p[0] <= mem_b[addr0_b];
    qb_p[1] <= qb_p[0];
    qb_p[2] <= qb_p[1];
  end
  assign q0_b = qb_p[2];

  assign s_flags = sel ? {idle_b, write_b, read_b, drain_b, done_b}
                       : {idle_a, write_a, read_a, drain_a, done_a};
  assign s_ce0   = sel ? ce0_b   : ce0_a;
  assign s_we0   = sel ? we0_b   : we0_a;
  assign s_valid = sel ? valid_b : valid_a;
  assign s_err   = sel ? err_b   : err_a;
  assign s_addr0 = sel ? addr0_b : addr0_a;
  assign s_errc  = sel ? errc_b  : errc_a;
  assign s_d0    = sel ? d0_b    : d0_a;
  assign s_mdata = sel ? mdata_b : mdata_a;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic [11:0] eerr);
    chk({tag, " flags"}, 32'(s_flags), 32'(5'b10000));
    chk({tag, " ce0"},   32'(s_ce0),   32'(0));
    chk({tag, " we0"},   32'(s_we0),   32'(0));
    chk({tag, " valid"}, 32'(s_valid), 32'(0));
    chk({tag, " errc"},  32'(s_errc),  32'(eerr));
    chk({tag, " err"},   32'(s_err),   32'(eerr != 12'd0));
  endtask

  // Pulse a run and check every cycle until the controller is back in IDLE
  task automatic run_op(input bit s, input logic [1:0] m, input logic [11:0] b,
                        input logic [11:0] n, input logic [15:0] sd, input int lat,
                        input int bad, input logic [15:0] badv, input logic [11:0] eerr,
                        input bit spam);
    int w, r, d, tot, j;
    logic [4:0]  ef;
    logic        ece, ewe, ev;
    logic [11:0] ea;
    logic [15:0] ed, evd;
    string       t;
    w   = (n == 12'd0 || m == 2'b01) ? 0 : int'(n);
    r   = (n == 12'd0 || m == 2'b00) ? 0 : int'(n);
    d   = (r > 0) ? lat : 0;
    tot = w + r + d + 2;
    @(negedge clk);
    sel = s; mode = m; base = b; cnt = n; seed = sd; run = 1'b1;
    for (int c = 0; c < tot; c++) begin
      @(negedge clk);
      if (c == 0) run = 1'b0;
      if (spam && c == 1) begin
        run = 1'b1; mode = 2'b01; base = 12'h555; cnt = 12'h007; seed = 16'h1234;
      end
      if (spam && c == 2) run = 1'b0;
      ef = 5'b10000; ece = 1'b0; ewe = 1'b0; ea = '0; ed = '0;
      if (c < w) begin
        ef = 5'b01000; ece = 1'b1; ewe = 1'b1;
        ea = b + 12'(c); ed = sd + 16'(c);
      end else if (c < w + r) begin
        ef = 5'b00100; ece = 1'b1; ea = b + 12'(c - w);
      end else if (c < w + r + d) begin
        ef = 5'b00010;
      end else if (c == w + r + d) begin
        ef = 5'b00001;
      end
      j   = c - w - lat;
      ev  = (r > 0) && (j >= 0) && (j < r);
      evd = (j == bad) ? badv : (sd + 16'(j));
      t = $sformatf("m%0d n%0d c%0d", m, n, c);
      chk({t, " flags"}, 32'(s_flags), 32'(ef));
      chk({t, " ce0"},   32'(s_ce0),   32'(ece));
      chk({t, " we0"},   32'(s_we0),   32'(ewe));
      chk({t, " addr0"}, 32'(s_addr0), 32'(ea));
      chk({t, " d0"},    32'(s_d0),    32'(ed));
      chk({t, " valid"}, 32'(s_valid), 32'(ev));
      if (ev) chk({t, " mdata"}, 32'(s_mdata), 32'(evd));
      if (c == 0) chk({t, " errc_clr"}, 32'(s_errc), 32'(0));
      if (c == tot - 1) begin
        chk({t, " errc"}, 32'(s_errc), 32'(eerr));
        chk({t, " err"},  32'(s_err),  32'(eerr != 12'd0));
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; run = 1'b0; sel = 1'b0; mode = '0; base = '0; cnt = '0; seed = '0;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    repeat (3) @(negedge clk);
    chk_idle("rst_a", 12'd0);
    sel = 1'b1;
    #1 chk_idle("rst_b", 12'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Write-then-read, plain and with address wrap
    run_op(1'b0, 2'b10, 12'h000, 12'd4, 16'h0100, 1, -1, 16'h0, 12'd0, 1'b0);
    run_op(1'b0, 2'b10, 12'hFFE, 12'd4, 16'h2000, 1, -1, 16'h0, 12'd0, 1'b0);
    // Write-only with data wrap and a stray run during WRITE; then read it back
    run_op(1'b0, 2'b00, 12'h010, 12'd3, 16'hFFFE, 1, -1, 16'h0, 12'd0, 1'b1);
    run_op(1'b0, 2'b01, 12'h010, 12'd3, 16'hFFFE, 1, -1, 16'h0, 12'd0, 1'b0);
    // Zero-length runs
    run_op(1'b0, 2'b00, 12'h123, 12'd0, 16'h0001, 1, -1, 16'h0, 12'd0, 1'b0);
    run_op(1'b0, 2'b01, 12'h123, 12'd0, 16'h0001, 1, -1, 16'h0, 12'd0, 1'b0);
    run_op(1'b1, 2'b10, 12'h123, 12'd0, 16'h0001, 3, -1, 16'h0, 12'd0, 1'b0);

    // Latency-3 read-only with one corrupted word
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      pl_we = 1'b1; pl_addr = 12'h020 + 12'(i);
      pl_data = (i == 1) ? 16'hDEAD : (16'h0500 + 16'(i));
      @(negedge clk);
    end
    pl_we = 1'b0;
    run_op(1'b1, 2'b01, 12'h020, 12'd3, 16'h0500, 3, 1, 16'hDEAD, CMP ? 12'd1 : 12'd0, 1'b0);
    @(negedge clk);
    chk_idle("hold_err", CMP ? 12'd1 : 12'd0);

    // Reserved mode: stays idle, nothing cleared
    sel = 1'b1; mode = 2'b11; cnt = 12'd5; run = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      run = 1'b0;
      chk_idle($sformatf("rsvd c%0d", c), CMP ? 12'd1 : 12'd0);
    end

    // Reset in the middle of READ while o_valid is high
    sel = 1'b1; mode = 2'b10; base = 12'h000; cnt = 12'd6; seed = 16'h0001; run = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      run = 1'b0;
    end
    chk("pre_rst flags", 32'(s_flags), 32'(5'b00100));
    chk("pre_rst valid", 32'(s_valid), 32'(1));
    #1 reset_n = 1'b0;
    #1 chk_idle("in_rst", 12'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("post_rst c%0d done", c), 32'(s_flags[0]), 32'(0));
      if (c == 0) chk_idle("post_rst", 12'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
